// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parameterised UART frame transmitter. One data word is accepted per
// four-phase req/ack handshake and serialised onto txd as:
//    start(0), data LSB first, optional parity, 1 or 2 stop bits(1).
// Bit timing comes from an internal baud counter running on clk.
//
//    state  | meaning
//    -------+----------------------------------------------------------
//    IDLE   | line high, waiting for req with ack low
//    START  | driving the start bit (txd=0)
//    DATA   | driving data bits, bit_idx = bit currently on the line
//    PARITY | driving the parity bit (only reachable when PARITY_EN=1)
//    STOP   | driving stop bits, bit_idx counts stop bits sent
//
// Ports:
//    clk   in   system clock, rising edge
//    clr   in   asynchronous active-high reset
//    req   in   request, data valid (four-phase handshake)
//    data  in   word to send, sampled only on acceptance
//    ack   out  acknowledge, high from acceptance until req seen low
//    busy  out  high while a frame is on the line
//    txd   out  serial line, idle high, registered
// ---------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 req,
   input  logic [DATA_BITS-1:0] data,
   output logic                 ack,
   output logic                 busy,
   output logic                 txd
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] BAUD_TC   = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
   localparam logic          PAR_INV   = (PARITY_ODD != 0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]           state;
   logic [CW-1:0]        baud_cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 parity_bit;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
         ack        <= 1'b0;
         busy       <= 1'b0;
         txd        <= 1'b1;
      end else begin
         // Handshake release is independent of the frame, so the host may
         // complete the four-phase cycle while bits are still going out.
         if (ack && !req) begin
            ack <= 1'b0;
         end

         if (state == IDLE) begin
            // ack must be low too: a req still held from the previous frame
            // must not retrigger.
            if (!ack && req) begin
               shift      <= data;
               parity_bit <= (^data) ^ PAR_INV;
               ack        <= 1'b1;
               busy       <= 1'b1;
               txd        <= 1'b0;
               state      <= START;
               baud_cnt   <= '0;
               bit_idx    <= '0;
            end
         end else if (baud_cnt != BAUD_TC) begin
            baud_cnt <= baud_cnt + 1'b1;
         end else begin
            baud_cnt <= '0;
            case (state)
               START: begin
                  txd     <= shift[0];
                  shift   <= shift >> 1;
                  bit_idx <= '0;
                  state   <= DATA;
               end
               DATA: begin
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     if (PARITY_EN != 0) begin
                        txd   <= parity_bit;
                        state <= PARITY;
                     end else begin
                        txd   <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     txd     <= shift[0];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
               PARITY: begin
                  txd     <= 1'b1;
                  bit_idx <= '0;
                  state   <= STOP;
               end
               STOP: begin
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= '0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
               default: begin
                  txd   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. Four instances cover the parameter
// sets of interest:
//    0: defaults (8N1)   1: 8E1   2: 8O1   3: 7 data bits, 2 stop bits
// Inputs are driven and outputs sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

   localparam int CPB = 16;

   logic       clk;
   logic       clr;
   logic [3:0] req;
   logic [7:0] data;
   logic [3:0] ack_v;
   logic [3:0] busy_v;
   logic [3:0] txd_v;

   int checks;
   int errors;

   uart_tx_frame dut0 (
      .clk(clk), .clr(clr), .req(req[0]), .data(data),
      .ack(ack_v[0]), .busy(busy_v[0]), .txd(txd_v[0])
   );

   uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .clr(clr), .req(req[1]), .data(data),
      .ack(ack_v[1]), .busy(busy_v[1]), .txd(txd_v[1])
   );

   uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .clr(clr), .req(req[2]), .data(data),
      .ack(ack_v[2]), .busy(busy_v[2]), .txd(txd_v[2])
   );

   uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) dut3 (
      .clk(clk), .clr(clr), .req(req[3]), .data(data[6:0]),
      .ack(ack_v[3]), .busy(busy_v[3]), .txd(txd_v[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sends one frame on instance s and checks it cycle by cycle.
   // Entry: at a falling edge with the instance idle and ack low (or req
   // already high from a re-request). Exit: at the falling edge where busy
   // is first low.
   task automatic run_frame(input int s, input int nd, input logic [7:0] d,
                            input int par_en, input logic par_bit,
                            input int stops, input bit drop_req,
                            input int rereq_at, input logic [7:0] next_d,
                            input string name);
      logic exp_bits [12];
      int   nb;
      int   total;
      logic bad;
      logic bad_txd;
      logic bad_busy;
      nb    = 1 + nd + par_en + stops;
      total = nb * CPB;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < nd; i++) exp_bits[1 + i] = d[i];
      if (par_en != 0) exp_bits[nd + 1] = par_bit;
      for (int j = 0; j < stops; j++) exp_bits[1 + nd + par_en + j] = 1'b1;

      data   = d;
      req[s] = 1'b1;
      @(negedge clk);
      checks++;
      if (ack_v[s] !== 1'b1 || txd_v[s] !== 1'b0 || busy_v[s] !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: ack=%b txd=%b busy=%b, expected ack=1 txd=0 busy=1",
                  name, ack_v[s], txd_v[s], busy_v[s]);
      end
      // The frame in flight must not follow later data changes.
      data = ~d;
      if (drop_req) req[s] = 1'b0;

      bad      = 1'b0;
      bad_txd  = 1'b0;
      bad_busy = 1'b0;
      for (int k = 0; k < total; k++) begin
         if (k > 0) @(negedge clk);
         if (txd_v[s] !== exp_bits[k / CPB] || busy_v[s] !== 1'b1 ||
             (rereq_at >= 0 && k > rereq_at && ack_v[s] !== 1'b0)) begin
            if (!bad) begin
               bad_txd  = txd_v[s];
               bad_busy = busy_v[s];
            end
            bad = 1'b1;
         end
         if (k == 1 && drop_req) begin
            checks++;
            if (ack_v[s] !== 1'b0) begin
               errors++;
               $display("FAIL %s ack_release: ack=%b, expected 0", name, ack_v[s]);
            end
         end
         if (k == rereq_at) begin
            data   = next_d;
            req[s] = 1'b1;
         end
         if ((k % CPB) == CPB - 1) begin
            checks++;
            if (bad) begin
               errors++;
               $display("FAIL %s bit %0d: txd=%b busy=%b, expected txd=%b busy=1 (ack low after re-request)",
                        name, k / CPB, bad_txd, bad_busy, exp_bits[k / CPB]);
            end
            bad = 1'b0;
         end
      end

      @(negedge clk);
      checks++;
      if (busy_v[s] !== 1'b0 || txd_v[s] !== 1'b1 ||
          (rereq_at >= 0 && ack_v[s] !== 1'b0)) begin
         errors++;
         $display("FAIL %s frame_end: busy=%b txd=%b ack=%b, expected busy=0 txd=1 ack=%0d",
                  name, busy_v[s], txd_v[s], ack_v[s], (rereq_at >= 0) ? 0 : 1);
      end
   endtask

   task automatic test_reset();
      clr  = 1'b1;
      req  = 4'b0000;
      data = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if (txd_v !== 4'hF || ack_v !== 4'h0 || busy_v !== 4'h0) begin
         errors++;
         $display("FAIL reset: txd=%b ack=%b busy=%b, expected txd=1111 ack=0000 busy=0000",
                  txd_v, ack_v, busy_v);
      end
      clr = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (txd_v !== 4'hF || busy_v !== 4'h0) begin
         errors++;
         $display("FAIL idle_after_reset: txd=%b busy=%b, expected 1111 0000", txd_v, busy_v);
      end
   endtask

   task automatic test_basic();
      run_frame(0, 8, 8'h55, 0, 1'b0, 1, 1'b1, -1, 8'h00, "basic_55");
      repeat (3) @(negedge clk);
   endtask

   task automatic test_parity();
      run_frame(1, 8, 8'h07, 1, 1'b1, 1, 1'b1, -1, 8'h00, "parity_even_07");
      repeat (3) @(negedge clk);
      run_frame(2, 8, 8'h07, 1, 1'b0, 1, 1'b1, -1, 8'h00, "parity_odd_07");
      repeat (3) @(negedge clk);
   endtask

   task automatic test_hold_req();
      logic bad;
      run_frame(0, 8, 8'hA5, 0, 1'b0, 1, 1'b0, -1, 8'h00, "hold_A5");
      bad = 1'b0;
      // req stays high to 400 cycles after it rose; no second frame.
      for (int k = 0; k < 400 - 161; k++) begin
         @(negedge clk);
         if (ack_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || txd_v[0] !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hold_no_retrigger: ack=%b busy=%b txd=%b, expected ack=1 busy=0 txd=1",
                  ack_v[0], busy_v[0], txd_v[0]);
      end
      req[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (ack_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: ack=%b, expected 0", ack_v[0]);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      run_frame(0, 8, 8'h0F, 0, 1'b0, 1, 1'b1, 100, 8'h3C, "b2b_first_0F");
      run_frame(0, 8, 8'h3C, 0, 1'b0, 1, 1'b1, -1, 8'h00, "b2b_second_3C");
      repeat (3) @(negedge clk);
   endtask

   task automatic test_clr_abort();
      data   = 8'hFF;
      req[0] = 1'b1;
      @(negedge clk);
      req[0] = 1'b0;
      repeat (49) @(negedge clk);
      checks++;
      if (busy_v[0] !== 1'b1 || txd_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL clr_pre: busy=%b txd=%b, expected busy=1 txd=1 (data bit of 0xFF)",
                  busy_v[0], txd_v[0]);
      end
      clr = 1'b1;
      #1;
      checks++;
      if (txd_v[0] !== 1'b1 || ack_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL clr_abort: txd=%b ack=%b busy=%b, expected txd=1 ack=0 busy=0",
                  txd_v[0], ack_v[0], busy_v[0]);
      end
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);
      run_frame(0, 8, 8'h3C, 0, 1'b0, 1, 1'b1, -1, 8'h00, "after_clr_3C");
      repeat (3) @(negedge clk);
   endtask

   task automatic test_stop2();
      run_frame(3, 7, 8'h41, 0, 1'b0, 2, 1'b1, -1, 8'h00, "stop2_7bit_41");
      repeat (3) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_parity();
      test_hold_req();
      test_back_to_back();
      test_clr_abort();
      test_stop2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
